sram_scan_ctrl: RTL and testbench

//  GPIO-side scan controller for the OpenRAM test chip. Shifts a 112-bit command frame in from pins,

---
 rtl/testchip_pkg.sv | 46 ++++
 rtl/sram_port_decode.sv | 38 +++
 rtl/sram_scan_ctrl.sv | 108 ++++++++++
 tb/tb_sram_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/testchip_pkg.sv
// Shared definitions for the OpenRAM test-chip scan controller: frame layout and FSM states.
package testchip_pkg;

  localparam int unsigned SCAN_W = 112;

  localparam int unsigned SEL_MSB    = 111;
  localparam int unsigned SEL_LSB    = 108;
  localparam int unsigned ADDR0_MSB  = 107;
  localparam int unsigned ADDR0_LSB  = 92;
  localparam int unsigned DIN0_MSB   = 91;
  localparam int unsigned DIN0_LSB   = 60;
  localparam int unsigned CSB0_BIT   = 59;
  localparam int unsigned WEB0_BIT   = 58;
  localparam int unsigned WMASK0_MSB = 57;
  localparam int unsigned WMASK0_LSB = 54;
  localparam int unsigned ADDR1_MSB  = 53;
  localparam int unsigned ADDR1_LSB  = 38;
  localparam int unsigned DIN1_MSB   = 37;
  localparam int unsigned DIN1_LSB   = 6;
  localparam int unsigned CSB1_BIT   = 5;
  localparam int unsigned WEB1_BIT   = 4;
  localparam int unsigned WMASK1_MSB = 3;
  localparam int unsigned WMASK1_LSB = 0;

  // Member order matches the bit layout above, MSB first.
  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } scan_frame_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sram_port_decode.sv
// Combinational macro select: one-hot active-low chip selects and read-data mux for the chosen macro.
module sram_port_decode
  import testchip_pkg::*;
#(
  parameter int unsigned              NUM_SRAMS = 12,
  parameter logic [NUM_SRAMS-1:0]     DP_MASK   = 12'h03F
) (
  input  logic [3:0]              sel,
  input  logic                    en,
  input  logic                    csb0,
  input  logic                    csb1,
  input  logic [NUM_SRAMS*32-1:0] dout0_i,
  input  logic [NUM_SRAMS*32-1:0] dout1_i,
  output logic [NUM_SRAMS-1:0]    csb0_o,
  output logic [NUM_SRAMS-1:0]    csb1_o,
  output logic [31:0]             dout0_sel,
  output logic [31:0]             dout1_sel
);

  // A sel beyond the macro count matches no k, leaving selects high and data zero.
  always_comb begin
    csb0_o    = '1;
    csb1_o    = '1;
    dout0_sel = '0;
    dout1_sel = '0;
    for (int k = 0; k < int'(NUM_SRAMS); k++) begin
      if (int'(sel) == k) begin
        if (en) begin
          csb0_o[k] = csb0;
          csb1_o[k] = DP_MASK[k] ? csb1 : 1'b1;
        end
        dout0_sel = dout0_i[32*k +: 32];
        dout1_sel = dout1_i[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/sram_scan_ctrl.sv
// GPIO scan controller: shifts in a command frame, launches one SRAM access, captures read data.
module sram_scan_ctrl
  import testchip_pkg::*;
#(
  parameter int unsigned          NUM_SRAMS = 12,
  parameter logic [NUM_SRAMS-1:0] DP_MASK   = 12'h03F
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    scan_en,
  input  logic                    scan_in,
  output logic                    scan_out,
  input  logic                    sram_load,
  input  logic                    global_csb,
  output logic                    busy,
  output logic [NUM_SRAMS-1:0]    csb0_o,
  output logic [NUM_SRAMS-1:0]    csb1_o,
  output logic                    web0_o,
  output logic                    web1_o,
  output logic [3:0]              wmask0_o,
  output logic [3:0]              wmask1_o,
  output logic [15:0]             addr0_o,
  output logic [15:0]             addr1_o,
  output logic [31:0]             din0_o,
  output logic [31:0]             din1_o,
  input  logic [NUM_SRAMS*32-1:0] dout0_i,
  input  logic [NUM_SRAMS*32-1:0] dout1_i
);

  scan_frame_t sr_q, sr_d;
  ctrl_state_t state_q, state_d;
  logic        csb_q;
  logic [31:0] dout0_q, dout1_q;
  logic [31:0] dout0_sel, dout1_sel;
  logic        launch;

  // Falling edge of global_csb starts exactly one access, whatever else is requested.
  assign launch = (state_q == IDLE) && csb_q && !global_csb;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The frame is frozen while an access is in flight so the broadcast fields stay stable.
  always_comb begin
    sr_d = sr_q;
    if (state_q == IDLE && !launch) begin
      if (sram_load) begin
        sr_d.din0 = dout0_q;
        sr_d.din1 = dout1_q;
      end else if (scan_en) begin
        sr_d = scan_frame_t'({sr_q[SCAN_W-2:0], scan_in});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      sr_q    <= '0;
      state_q <= IDLE;
      csb_q   <= 1'b1;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      sr_q    <= sr_d;
      state_q <= state_d;
      csb_q   <= global_csb;
      if (state_q == CAPTURE) begin
        dout0_q <= dout0_sel;
        dout1_q <= dout1_sel;
      end
    end
  end

  sram_port_decode #(
    .NUM_SRAMS (NUM_SRAMS),
    .DP_MASK   (DP_MASK)
  ) u_decode (
    .sel       (sr_q.sel),
    .en        (state_q == ACCESS),
    .csb0      (sr_q.csb0),
    .csb1      (sr_q.csb1),
    .dout0_i   (dout0_i),
    .dout1_i   (dout1_i),
    .csb0_o    (csb0_o),
    .csb1_o    (csb1_o),
    .dout0_sel (dout0_sel),
    .dout1_sel (dout1_sel)
  );

  assign busy     = (state_q != IDLE);
  assign scan_out = sr_q[SCAN_W-1];
  assign web0_o   = sr_q.web0;
  assign web1_o   = sr_q.web1;
  assign wmask0_o = sr_q.wmask0;
  assign wmask1_o = sr_q.wmask1;
  assign addr0_o  = sr_q.addr0;
  assign addr1_o  = sr_q.addr1;
  assign din0_o   = sr_q.din0;
  assign din1_o   = sr_q.din1;

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Directed bench for sram_scan_ctrl: reset, write, read-back, single-port, edge cases, mid-access reset.
module tb_sram_scan_ctrl;

  localparam int unsigned N = 12;

  logic           clk = 1'b0;
  logic           resetb;
  logic           scan_en;
  logic           scan_in;
  logic           scan_out;
  logic           sram_load;
  logic           global_csb;
  logic           busy;
  logic [N-1:0]   csb0_o, csb1_o;
  logic           web0_o, web1_o;
  logic [3:0]     wmask0_o, wmask1_o;
  logic [15:0]    addr0_o, addr1_o;
  logic [31:0]    din0_o, din1_o;
  logic [N*32-1:0] dout0, dout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_scan_ctrl dut (
    .clk        (clk),
    .resetb     (resetb),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .sram_load  (sram_load),
    .global_csb (global_csb),
    .busy       (busy),
    .csb0_o     (csb0_o),
    .csb1_o     (csb1_o),
    .web0_o     (web0_o),
    .web1_o     (web1_o),
    .wmask0_o   (wmask0_o),
    .wmask1_o   (wmask1_o),
    .addr0_o    (addr0_o),
    .addr1_o    (addr1_o),
    .din0_o     (din0_o),
    .din1_o     (din1_o),
    .dout0_i    (dout0),
    .dout1_i    (dout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic shift_frame(input logic [111:0] f);
    scan_en = 1'b1;
    for (int i = 111; i >= 0; i--) begin
      scan_in = f[i];
      step();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  logic [111:0] fw, fr, fr_exp, fs, ff, got;

  initial begin
    for (int k = 0; k < int'(N); k++) begin
      dout0[32*k +: 32] = 32'hA000_0000 + k;
      dout1[32*k +: 32] = 32'hB000_0000 + k;
    end
    dout0[64 +: 32] = 32'h2;
    dout1[64 +: 32] = 32'h10;

    fw = {4'd2, 16'd1, 32'h2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF};
    fr = {4'd2, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd3, 32'h0, 1'b0, 1'b1, 4'h0};
    fr_exp = {4'd2, 16'd1, 32'h2, 1'b0, 1'b1, 4'h0, 16'd3, 32'h10, 1'b0, 1'b1, 4'h0};
    fs = {4'd9, 16'h5, 32'h0, 1'b0, 1'b1, 4'h0, 16'h6, 32'h0, 1'b0, 1'b1, 4'h0};
    ff = {4'hF, 16'h7, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'h0, 16'h8, 32'hCAFE_F00D, 1'b0, 1'b1, 4'h0};

    resetb = 1'b0; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
    step(); step(); step();
    check("rst_csb0", csb0_o, 12'hFFF);
    check("rst_csb1", csb1_o, 12'hFFF);
    check("rst_busy", busy, 1'b0);
    check("rst_scan_out", scan_out, 1'b0);
    resetb = 1'b1;
    step();

    // Write to macro 2
    shift_frame(fw);
    check("wr_addr0", addr0_o, 16'd1);
    check("wr_din0", din0_o, 32'h2);
    check("wr_web0", web0_o, 1'b0);
    check("wr_wmask0", wmask0_o, 4'hF);
    global_csb = 1'b0;
    step();
    check("wr_access_csb0", csb0_o, 12'hFFB);
    check("wr_access_csb1", csb1_o, 12'hFFF);
    check("wr_access_busy", busy, 1'b1);
    global_csb = 1'b1;
    step();
    check("wr_capture_csb0", csb0_o, 12'hFFF);
    step();
    check("wr_idle_busy", busy, 1'b0);

    // Read back macro 2 on both ports, load and shift out
    shift_frame(fr);
    global_csb = 1'b0;
    step();
    check("rd_access_csb0", csb0_o, 12'hFFB);
    check("rd_access_csb1", csb1_o, 12'hFFB);
    global_csb = 1'b1;
    step(); step();
    sram_load = 1'b1;
    step();
    sram_load = 1'b0;
    check("rd_load_din0", din0_o, 32'h2);
    check("rd_load_din1", din1_o, 32'h10);
    got = '0;
    scan_en = 1'b1;
    scan_in = 1'b0;
    for (int i = 111; i >= 0; i--) begin
      got[i] = scan_out;
      step();
    end
    scan_en = 1'b0;
    check("rd_shift_out", got, fr_exp);

    // Single-port macro 9: port1 select must stay high
    shift_frame(fs);
    global_csb = 1'b0;
    step();
    check("sp_csb0", csb0_o, 12'hDFF);
    check("sp_csb1", csb1_o, 12'hFFF);

    // global_csb held low: one pulse only
    step();
    check("hold_capture_csb0", csb0_o, 12'hFFF);
    step();
    check("hold_idle1_busy", busy, 1'b0);
    check("hold_idle1_csb0", csb0_o, 12'hFFF);
    step();
    check("hold_idle2_busy", busy, 1'b0);
    step();
    check("hold_idle3_csb0", csb0_o, 12'hFFF);
    global_csb = 1'b1;
    step();

    // scan_en while busy leaves the frame alone
    global_csb = 1'b0;
    step();
    global_csb = 1'b1;
    scan_en = 1'b1;
    scan_in = 1'b1;
    step(); step();
    scan_en = 1'b0;
    scan_in = 1'b0;
    check("busy_scan_addr0", addr0_o, 16'h5);
    check("busy_scan_addr1", addr1_o, 16'h6);
    check("busy_scan_wmask1", wmask1_o, 4'h0);

    // Out-of-range select: no pulse, loaded data zero
    shift_frame(ff);
    global_csb = 1'b0;
    step();
    check("oor_busy", busy, 1'b1);
    check("oor_csb0", csb0_o, 12'hFFF);
    check("oor_csb1", csb1_o, 12'hFFF);
    global_csb = 1'b1;
    step(); step();
    sram_load = 1'b1;
    step();
    sram_load = 1'b0;
    check("oor_din0", din0_o, 32'h0);
    check("oor_din1", din1_o, 32'h0);
    check("oor_addr1", addr1_o, 16'h8);

    // Reset during ACCESS
    shift_frame(fw);
    global_csb = 1'b0;
    step();
    check("rstacc_csb0_pre", csb0_o, 12'hFFB);
    resetb = 1'b0;
    global_csb = 1'b1;
    step();
    check("rstacc_csb0", csb0_o, 12'hFFF);
    check("rstacc_csb1", csb1_o, 12'hFFF);
    check("rstacc_busy", busy, 1'b0);
    check("rstacc_addr0", addr0_o, 16'h0);
    check("rstacc_din0", din0_o, 32'h0);
    resetb = 1'b1;
    step();
    check("rstacc_after_csb0", csb0_o, 12'hFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
